writeback_queue: RTL and testbench

- Write-back stage directly upstream of the 32-entry register bank; sole driver of the bank's write port (enable, address, data).
- Accepts results from two producers, the ALU and the load unit, buffers them in a small in-order FIFO, and retires one register write per cycle.
- Provides a lookup port so decode can detect and forward results that are pending but not yet written to the bank.

---
 rtl/writeback_queue.sv | 92 +++++++++
 tb/tb_writeback_queue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Write-back FIFO feeding the register bank from ALU and load producers; result reaches bank 2 edges after acceptance.
// Backpressure: ldReady needs one free slot, aluReady needs two when a load is also offered; popping does not free a slot early.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aluValid,
  output logic              aluReady,
  input  logic [ADDR_W-1:0] aluAddr,
  input  logic [DATA_W-1:0] aluData,
  input  logic              ldValid,
  output logic              ldReady,
  input  logic [ADDR_W-1:0] ldAddr,
  input  logic [DATA_W-1:0] ldData,
  output logic              regWriteEnable,
  output logic [ADDR_W-1:0] regWriteAddr,
  output logic [DATA_W-1:0] regWriteData,
  input  logic [ADDR_W-1:0] qryAddr,
  output logic              qryHit,
  output logic [DATA_W-1:0] qryData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] entAddr [DEPTH];
  logic [DATA_W-1:0] entData [DEPTH];
  logic [PW-1:0]     wrPtr, rdPtr, aluSlot, idx;
  logic [CW-1:0]     count, free;
  logic              ldPush, aluPush, pop;

  assign free    = CW'(DEPTH) - count;
  // Readies drop during reset so nothing offered in that cycle looks accepted.
  assign ldReady  = rst && (free >= CW'(1));
  assign aluReady = rst && (ldValid ? (free >= CW'(2)) : (free >= CW'(1)));
  assign ldPush   = ldValid && ldReady;
  assign aluPush  = aluValid && aluReady;
  assign pop      = (count != '0);
  assign aluSlot  = wrPtr + PW'(ldPush);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count          <= '0;
      wrPtr          <= '0;
      rdPtr          <= '0;
      regWriteEnable <= 1'b0;
      regWriteAddr   <= '0;
      regWriteData   <= '0;
    end else begin
      if (ldPush) begin
        entAddr[wrPtr] <= ldAddr;
        entData[wrPtr] <= ldData;
      end
      if (aluPush) begin
        entAddr[aluSlot] <= aluAddr;
        entData[aluSlot] <= aluData;
      end
      wrPtr <= wrPtr + PW'(ldPush) + PW'(aluPush);
      count <= count + CW'(ldPush) + CW'(aluPush) - CW'(pop);
      if (pop) begin
        regWriteEnable <= 1'b1;
        regWriteAddr   <= entAddr[rdPtr];
        regWriteData   <= entData[rdPtr];
        rdPtr          <= rdPtr + PW'(1);
      end else begin
        regWriteEnable <= 1'b0;
      end
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins; output register is older than any FIFO entry.
  always_comb begin
    qryHit  = 1'b0;
    qryData = '0;
    idx     = '0;
    if (regWriteEnable && (regWriteAddr == qryAddr)) begin
      qryHit  = 1'b1;
      qryData = regWriteData;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PW'(i);
      if ((CW'(i) < count) && (entAddr[idx] == qryAddr)) begin
        qryHit  = 1'b1;
        qryData = entData[idx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_writeback_queue;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        aluValid = 1'b0, ldValid = 1'b0;
  logic        aluReady, ldReady;
  logic [4:0]  aluAddr = '0, ldAddr = '0, qryAddr = '0;
  logic [31:0] aluData = '0, ldData = '0;
  logic        regWriteEnable, qryHit;
  logic [4:0]  regWriteAddr;
  logic [31:0] regWriteData, qryData;

  int tests = 0;
  int fails = 0;

  // Reference model: pending results in acceptance order, plus the bank write register.
  ent_t        mq[$];
  ent_t        acc[$];
  logic        m_en   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  writeback_queue dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluReady(aluReady), .aluAddr(aluAddr), .aluData(aluData),
    .ldValid(ldValid), .ldReady(ldReady), .ldAddr(ldAddr), .ldData(ldData),
    .regWriteEnable(regWriteEnable), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
    .qryAddr(qryAddr), .qryHit(qryHit), .qryData(qryData)
  );

  always #5 clk = ~clk;

  function automatic int mfree();
    return 4 - mq.size();
  endfunction

  function automatic logic m_ldr();
    return rst && (mfree() >= 1);
  endfunction

  function automatic logic m_alur();
    return rst && (ldValid ? (mfree() >= 2) : (mfree() >= 1));
  endfunction

  function automatic logic [32:0] m_qry(input logic [4:0] a);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return {1'b1, mq[i].d};
    if (m_en && m_addr == a) return {1'b1, m_data};
    return 33'h0;
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic lp, ap;
    ent_t le, ae, h;
    lp = ldValid && m_ldr();
    ap = aluValid && m_alur();
    le = {ldAddr, ldData};
    ae = {aluAddr, aluData};
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      if (mq.size() > 0) begin
        h = mq.pop_front();
        m_en = 1'b1; m_addr = h.a; m_data = h.d;
      end else begin
        m_en = 1'b0;
      end
      if (lp) begin mq.push_back(le); acc.push_back(le); end
      if (ap) begin mq.push_back(ae); acc.push_back(ae); end
    end
    #1;
  endtask

  task automatic idle_inputs();
    ldValid = 1'b0; aluValid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle_inputs();
    tick(); tick();
    tests++;
    if ({regWriteEnable, regWriteAddr, regWriteData} !== 38'h0)
      begin fails++; $display("FAIL reset_regs got en=%b a=%0d d=%h want 0/0/0", regWriteEnable, regWriteAddr, regWriteData); end
    rst = 1'b1; qryAddr = 5'd5;
    #1;
    tests++;
    if ({aluReady, ldReady} !== 2'b11)
      begin fails++; $display("FAIL reset_ready got alu=%b ld=%b want 1/1", aluReady, ldReady); end
    tests++;
    if (qryHit !== 1'b0)
      begin fails++; $display("FAIL reset_qry got %b want 0", qryHit); end
    tick();
    tests++;
    if (regWriteEnable !== 1'b0)
      begin fails++; $display("FAIL reset_idle got en=%b want 0", regWriteEnable); end
  endtask

  task automatic test_single_alu();
    aluValid = 1'b1; aluAddr = 5'd3; aluData = 32'h1234;
    #1;
    tests++;
    if (aluReady !== 1'b1)
      begin fails++; $display("FAIL single_ready got %b want 1", aluReady); end
    tick();  // edge E
    idle_inputs();
    tests++;
    if (regWriteEnable !== 1'b0)
      begin fails++; $display("FAIL single_E got en=%b want 0", regWriteEnable); end
    tick();  // edge E+1
    tests++;
    if ({regWriteEnable, regWriteAddr, regWriteData} !== {1'b1, 5'd3, 32'h1234})
      begin fails++; $display("FAIL single_E1 got en=%b a=%0d d=%h want 1/3/1234", regWriteEnable, regWriteAddr, regWriteData); end
    tick();  // edge E+2
    tests++;
    if ({regWriteEnable, regWriteAddr, regWriteData} !== {1'b0, 5'd3, 32'h1234})
      begin fails++; $display("FAIL single_E2 got en=%b a=%0d d=%h want 0/3/1234", regWriteEnable, regWriteAddr, regWriteData); end
  endtask

  task automatic test_simultaneous();
    ldValid = 1'b1; ldAddr = 5'd7; ldData = 32'hAAAA;
    aluValid = 1'b1; aluAddr = 5'd8; aluData = 32'hBBBB;
    tick();
    idle_inputs();
    tick();
    tests++;
    if ({regWriteEnable, regWriteAddr, regWriteData} !== {1'b1, 5'd7, 32'hAAAA})
      begin fails++; $display("FAIL simul_first got en=%b a=%0d d=%h want 1/7/aaaa", regWriteEnable, regWriteAddr, regWriteData); end
    tick();
    tests++;
    if ({regWriteEnable, regWriteAddr, regWriteData} !== {1'b1, 5'd8, 32'hBBBB})
      begin fails++; $display("FAIL simul_second got en=%b a=%0d d=%h want 1/8/bbbb", regWriteEnable, regWriteAddr, regWriteData); end
    tick();
    tests++;
    if (regWriteEnable !== 1'b0)
      begin fails++; $display("FAIL simul_done got en=%b want 0", regWriteEnable); end
  endtask

  task automatic test_back_to_back();
    int   nl, na;
    logic la, aa;
    ent_t obs[$];
    nl = 1; na = 2;
    acc.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      ldValid = (nl <= 11); ldAddr = 5'(nl); ldData = 32'hD000 + 32'(nl);
      aluValid = (na <= 12); aluAddr = 5'(na); aluData = 32'hD000 + 32'(na);
      qryAddr = 5'($urandom_range(1, 12));
      #1;
      if (rst) begin
        tests++;
        if ({aluReady, ldReady} !== {m_alur(), m_ldr()})
          begin fails++; $display("FAIL b2b_ready cyc=%0d got alu=%b ld=%b want %b/%b", cyc, aluReady, ldReady, m_alur(), m_ldr()); end
      end
      tests++;
      if ({qryHit, qryData} !== m_qry(qryAddr))
        begin fails++; $display("FAIL b2b_qry cyc=%0d got %b/%h want %h", cyc, qryHit, qryData, m_qry(qryAddr)); end
      la = ldValid && m_ldr();
      aa = aluValid && m_alur();
      tick();
      if (la) nl += 2;
      if (aa) na += 2;
      tests++;
      if ({regWriteEnable, regWriteAddr, regWriteData} !== {m_en, m_addr, m_data})
        begin fails++; $display("FAIL b2b_write cyc=%0d got en=%b a=%0d d=%h want %b/%0d/%h", cyc, regWriteEnable, regWriteAddr, regWriteData, m_en, m_addr, m_data); end
      if (regWriteEnable) obs.push_back({regWriteAddr, regWriteData});
    end
    idle_inputs();
    tests++;
    if (obs.size() != 12 || acc.size() != 12)
      begin fails++; $display("FAIL b2b_count got writes=%0d accepted=%0d want 12/12", obs.size(), acc.size()); end
    for (int i = 0; i < obs.size() && i < acc.size(); i++) begin
      tests++;
      if (obs[i] !== acc[i])
        begin fails++; $display("FAIL b2b_order idx=%0d got %h want %h", i, obs[i], acc[i]); end
    end
  endtask

  task automatic test_dup_lookup();
    ldValid = 1'b1; ldAddr = 5'd4; ldData = 32'h11;
    aluValid = 1'b1; aluAddr = 5'd4; aluData = 32'h22;
    qryAddr = 5'd4;
    tick();
    idle_inputs();
    #1;
    tests++;
    if ({qryHit, qryData} !== {1'b1, 32'h22})
      begin fails++; $display("FAIL dup_both got %b/%h want 1/22", qryHit, qryData); end
    tick();  // r4=0x11 being written, 0x22 still queued
    tests++;
    if ({qryHit, qryData} !== {1'b1, 32'h22})
      begin fails++; $display("FAIL dup_older_out got %b/%h want 1/22", qryHit, qryData); end
    tick();  // r4=0x22 in output register
    tests++;
    if ({qryHit, qryData, regWriteData} !== {1'b1, 32'h22, 32'h22})
      begin fails++; $display("FAIL dup_younger_out got %b/%h wd=%h want 1/22/22", qryHit, qryData, regWriteData); end
    tick();
    tests++;
    if ({qryHit, qryData} !== 33'h0)
      begin fails++; $display("FAIL dup_gone got %b/%h want 0/0", qryHit, qryData); end
  endtask

  task automatic test_reset_mid();
    ldValid = 1'b1; ldAddr = 5'd20; ldData = 32'h100;
    aluValid = 1'b1; aluAddr = 5'd21; aluData = 32'h101;
    tick();
    ldAddr = 5'd22; ldData = 32'h102; aluAddr = 5'd23; aluData = 32'h103;
    tick();
    idle_inputs();
    qryAddr = 5'd22;
    #1;
    tests++;
    if ({qryHit, qryData} !== {1'b1, 32'h102})
      begin fails++; $display("FAIL rmid_pending got %b/%h want 1/102", qryHit, qryData); end
    rst = 1'b0; ldValid = 1'b1; ldAddr = 5'd24; ldData = 32'h104;
    tick();
    rst = 1'b1; idle_inputs();
    #1;
    tests++;
    if ({regWriteEnable, regWriteAddr, regWriteData, qryHit} !== 39'h0)
      begin fails++; $display("FAIL rmid_cleared got en=%b a=%0d d=%h hit=%b want all 0", regWriteEnable, regWriteAddr, regWriteData, qryHit); end
    tests++;
    if ({aluReady, ldReady} !== 2'b11)
      begin fails++; $display("FAIL rmid_ready got %b/%b want 1/1", aluReady, ldReady); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (regWriteEnable !== 1'b0)
        begin fails++; $display("FAIL rmid_discard cyc=%0d got en=%b a=%0d want 0", i, regWriteEnable, regWriteAddr); end
    end
    aluValid = 1'b1; aluAddr = 5'd9; aluData = 32'h5;
    tick();
    idle_inputs();
    tests++;
    if (regWriteEnable !== 1'b0)
      begin fails++; $display("FAIL rmid_new_E got en=%b want 0", regWriteEnable); end
    tick();
    tests++;
    if ({regWriteEnable, regWriteAddr, regWriteData} !== {1'b1, 5'd9, 32'h5})
      begin fails++; $display("FAIL rmid_new_E1 got en=%b a=%0d d=%h want 1/9/5", regWriteEnable, regWriteAddr, regWriteData); end
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 500; cyc++) begin
      rst      = ($urandom_range(0, 59) != 0);
      ldValid  = ($urandom_range(0, 3) != 0);
      aluValid = ($urandom_range(0, 3) != 0);
      ldAddr   = 5'($urandom_range(0, 7));
      aluAddr  = 5'($urandom_range(0, 7));
      ldData   = $urandom;
      aluData  = $urandom;
      qryAddr  = 5'($urandom_range(0, 7));
      #1;
      if (rst) begin
        tests++;
        if ({aluReady, ldReady} !== {m_alur(), m_ldr()})
          begin fails++; $display("FAIL rnd_ready cyc=%0d got alu=%b ld=%b want %b/%b", cyc, aluReady, ldReady, m_alur(), m_ldr()); end
      end
      tests++;
      if ({qryHit, qryData} !== m_qry(qryAddr))
        begin fails++; $display("FAIL rnd_qry cyc=%0d a=%0d got %b/%h want %h", cyc, qryAddr, qryHit, qryData, m_qry(qryAddr)); end
      tick();
      tests++;
      if ({regWriteEnable, regWriteAddr, regWriteData} !== {m_en, m_addr, m_data})
        begin fails++; $display("FAIL rnd_write cyc=%0d got en=%b a=%0d d=%h want %b/%0d/%h", cyc, regWriteEnable, regWriteAddr, regWriteData, m_en, m_addr, m_data); end
    end
    rst = 1'b1;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_back_to_back();
    test_dup_lookup();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
